// File: rtl/sprite_capture.sv
// sprite_capture: samples a serial 1-bit pixel stream inside a 16-pixel window
// and packs each scanline into two bytes for a 32x8 sprite RAM, using the same
// layout the sprite renderer reads back (row r: {r,0}=pixels 0..7, {r,1}=8..15).
module sprite_capture #(
  parameter int HEIGHT      = 16,   // rows captured per frame, 1..16
  parameter int PIXEL_DELAY = 1,    // cycles between hstart and first sample, 0..7
  parameter bit INVERT      = 1'b0  // store inverted pixels
) (
  input  logic       clk,
  input  logic       reset,     // synchronous, active low
  input  logic       arm,
  input  logic       abort,
  input  logic       vstart,
  input  logic       load,
  input  logic       hstart,
  input  logic       hmirror,
  input  logic       vmirror,
  input  logic       gfx,
  output logic [4:0] ram_addr,
  output logic [7:0] ram_bits,
  output logic       ram_we,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, WAIT_VSTART, WAIT_LOAD, WAIT_HSTART, DELAY, SHIFT, STORE_LO, STORE_HI
  } state_t;

  localparam logic [3:0] LAST_ROW = 4'(HEIGHT - 1);
  // Only meaningful when PIXEL_DELAY > 0; the DELAY state is skipped otherwise.
  localparam logic [2:0] LAST_DLY = 3'(PIXEL_DELAY - 1);

  state_t      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [3:0]  xcount_q, xcount_d;
  logic [2:0]  dcount_q, dcount_d;
  logic        hmir_q, hmir_d;
  logic        vmir_q, vmir_d;
  logic [15:0] rowbuf_q, rowbuf_d;
  logic [4:0]  ram_addr_q, ram_addr_d;
  logic [7:0]  ram_bits_q, ram_bits_d;
  logic        ram_we_q, ram_we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  bit_idx_s;
  logic [3:0]  row_eff_s;

  // Mirrored pixel bit position and mirrored RAM row for the current sample/store.
  always_comb begin
    bit_idx_s = hmir_q ? ~xcount_q : xcount_q;
    row_eff_s = vmir_q ? ~row_q : row_q;
  end

  // Next-state and registered-output logic; abort overrides everything else.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    xcount_d   = xcount_q;
    dcount_d   = dcount_q;
    hmir_d     = hmir_q;
    vmir_d     = vmir_q;
    rowbuf_d   = rowbuf_q;
    ram_addr_d = ram_addr_q;
    ram_bits_d = ram_bits_q;
    ram_we_d   = 1'b0;
    done_d     = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_d = WAIT_VSTART;
            row_d   = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end
        WAIT_VSTART: begin
          if (vstart) begin
            hmir_d  = hmirror;
            vmir_d  = vmirror;
            state_d = WAIT_LOAD;
          end else begin
            state_d = WAIT_VSTART;
          end
        end
        WAIT_LOAD: begin
          if (load) begin
            state_d = WAIT_HSTART;
          end else begin
            state_d = WAIT_LOAD;
          end
        end
        WAIT_HSTART: begin
          if (hstart) begin
            xcount_d = 4'd0;
            dcount_d = 3'd0;
            state_d  = (PIXEL_DELAY == 0) ? SHIFT : DELAY;
          end else begin
            state_d = WAIT_HSTART;
          end
        end
        DELAY: begin
          if (dcount_q == LAST_DLY) begin
            state_d = SHIFT;
          end else begin
            dcount_d = dcount_q + 3'd1;
          end
        end
        SHIFT: begin
          rowbuf_d[bit_idx_s] = gfx ^ INVERT;
          xcount_d = xcount_q + 4'd1;  // wraps 15 -> 0 on the last pixel
          if (xcount_q == 4'd15) begin
            state_d = STORE_LO;
          end else begin
            state_d = SHIFT;
          end
        end
        STORE_LO: begin
          ram_we_d   = 1'b1;
          ram_addr_d = {row_eff_s, 1'b0};
          ram_bits_d = rowbuf_q[7:0];
          state_d    = STORE_HI;
        end
        STORE_HI: begin
          ram_we_d   = 1'b1;
          ram_addr_d = {row_eff_s, 1'b1};
          ram_bits_d = rowbuf_q[15:8];
          if (row_q == LAST_ROW) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            row_d   = row_q + 4'd1;
            state_d = WAIT_LOAD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      row_q      <= 4'd0;
      xcount_q   <= 4'd0;
      dcount_q   <= 3'd0;
      hmir_q     <= 1'b0;
      vmir_q     <= 1'b0;
      rowbuf_q   <= 16'd0;
      ram_addr_q <= 5'd0;
      ram_bits_q <= 8'd0;
      ram_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      xcount_q   <= xcount_d;
      dcount_q   <= dcount_d;
      hmir_q     <= hmir_d;
      vmir_q     <= vmir_d;
      rowbuf_q   <= rowbuf_d;
      ram_addr_q <= ram_addr_d;
      ram_bits_q <= ram_bits_d;
      ram_we_q   <= ram_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_bits = ram_bits_q;
  assign ram_we   = ram_we_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
